// File: rtl/a23_copro_bridge.sv
// Bridge that lets a non-core agent issue single CP15 register reads/writes over the copro port.
// Latency from the i_req sampling edge (immediate grant, no stall): write ack in cycle 3, read ack in cycle 4, range error ack in cycle 1.
// Waits in REQ for grant and holds ISSUE while i_fetch_stall is high; i_req is ignored whenever o_busy is high.
//
// Ports: i_clk/i_rst (sync active-high); requester side i_req/i_we/i_crn/i_wdata -> o_busy/o_ack/o_err/o_rdata;
//        arbiter side o_copro_req/i_copro_gnt; copro side o_copro_* / i_copro_read_data, qualified by i_fetch_stall.
// Optional: define A23_COPRO_GNT_TIMEOUT_EN to abort with o_err after GNT_TIMEOUT REQ cycles without grant.
module a23_copro_bridge #(
    parameter int GNT_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [3:0]  i_crn,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_copro_req,
    input  logic        i_copro_gnt,
    input  logic        i_fetch_stall,
    output logic [2:0]  o_copro_opcode1,
    output logic [2:0]  o_copro_opcode2,
    output logic [3:0]  o_copro_crn,
    output logic [3:0]  o_copro_crm,
    output logic [3:0]  o_copro_num,
    output logic [1:0]  o_copro_operation,
    output logic [31:0] o_copro_write_data,
    input  logic [31:0] i_copro_read_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  crn_q, crn_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef A23_COPRO_GNT_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    // Counter value seen in the last REQ cycle before the abort.
    localparam logic [15:0] CntLast = 16'(GNT_TIMEOUT - 1);
`else
    logic unused_gnt_timeout;
    assign unused_gnt_timeout = (GNT_TIMEOUT > 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            crn_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef A23_COPRO_GNT_TIMEOUT_EN
            cnt_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            crn_q   <= crn_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef A23_COPRO_GNT_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        crn_d   = crn_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef A23_COPRO_GNT_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef A23_COPRO_GNT_TIMEOUT_EN
                cnt_d = 16'd0;
`endif
                if (i_req) begin
                    we_d    = i_we;
                    crn_d   = i_crn;
                    wdata_d = i_wdata;
                    // Previous result is only held until the next accepted request.
                    rdata_d = 32'd0;
                    // Only CP15 registers 0..7 exist; reject the rest without touching the port.
                    if (i_crn[3]) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_copro_gnt) begin
                    state_d = S_ISSUE;
                end
`ifdef A23_COPRO_GNT_TIMEOUT_EN
                // Grant in the timeout cycle takes priority over the abort.
                else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_ISSUE: begin
                if (!i_fetch_stall) begin
                    state_d = we_q ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // The coprocessor registered its read data on the accepting edge; take it regardless of stall.
                rdata_d = i_copro_read_data;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy             = (state_q != S_IDLE);
        o_ack              = (state_q == S_DONE);
        o_err              = (state_q == S_DONE) && err_q;
        o_rdata            = rdata_q;
        o_copro_req        = (state_q == S_REQ) || (state_q == S_ISSUE) || (state_q == S_CAPTURE);
        o_copro_opcode1    = 3'd0;
        o_copro_opcode2    = 3'd0;
        o_copro_crm        = 4'd0;
        o_copro_num        = 4'hf;
        o_copro_crn        = 4'd0;
        o_copro_operation  = 2'd0;
        o_copro_write_data = 32'd0;
        if (state_q == S_ISSUE) begin
            o_copro_crn        = crn_q;
            o_copro_operation  = we_q ? 2'd2 : 2'd1;
            o_copro_write_data = wdata_q;
        end else if (state_q == S_CAPTURE) begin
            o_copro_crn = crn_q;
        end
    end

endmodule

// File: tb/tb_a23_copro_bridge.sv
// Directed bench for a23_copro_bridge with a small CP15 register model on the copro side.
module tb_a23_copro_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  crn;
    logic [31:0] wdata;
    logic        busy, ack, err;
    logic [31:0] rdata;
    logic        copro_req, copro_gnt, fetch_stall;
    logic [2:0]  op1, op2;
    logic [3:0]  c_crn, c_crm, c_num;
    logic [1:0]  c_op;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    a23_copro_bridge #(.GNT_TIMEOUT(4)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req              (req),
        .i_we               (we),
        .i_crn              (crn),
        .i_wdata            (wdata),
        .o_busy             (busy),
        .o_ack              (ack),
        .o_err              (err),
        .o_rdata            (rdata),
        .o_copro_req        (copro_req),
        .i_copro_gnt        (copro_gnt),
        .i_fetch_stall      (fetch_stall),
        .o_copro_opcode1    (op1),
        .o_copro_opcode2    (op2),
        .o_copro_crn        (c_crn),
        .o_copro_crm        (c_crm),
        .o_copro_num        (c_num),
        .o_copro_operation  (c_op),
        .o_copro_write_data (c_wdata),
        .i_copro_read_data  (c_rdata)
    );

    // Coprocessor register file: accepts accesses on edges without stall, read data registered.
    logic [31:0] cregs [8];
    initial begin
        for (int i = 0; i < 8; i++) cregs[i] = 32'd0;
        cregs[0] = 32'h1337_4141;
        cregs[2] = 32'h0000_2222;
        c_rdata  = 32'd0;
    end
    always @(posedge clk) begin
        if (!fetch_stall && c_op == 2'd2) cregs[c_crn[2:0]] <= c_wdata;
        if (!fetch_stall && c_op == 2'd1) c_rdata <= cregs[c_crn[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and returns ack latency (cycles after the sampling edge), data and status.
    task automatic run_op(input logic t_we, input logic [3:0] t_crn, input logic [31:0] t_wdata,
                          input int gnt_wait, input int stall_n,
                          output int lat, output logic [31:0] rd, output logic er, output logic saw_req);
        int stalled = 0;
        lat = 0; rd = 32'hx; er = 1'bx; saw_req = 1'b0;
        @(negedge clk);
        req = 1'b1; we = t_we; crn = t_crn; wdata = t_wdata;
        copro_gnt = (gnt_wait == 0);
        fetch_stall = 1'b0;
        @(posedge clk);
        #1 req = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (copro_req) saw_req = 1'b1;
            if (cyc >= gnt_wait) copro_gnt = 1'b1;
            if (c_op != 2'd0) begin
                check("issue_op", {30'd0, c_op}, t_we ? 32'd2 : 32'd1);
                check("issue_crn", {28'd0, c_crn}, {28'd0, t_crn});
                if (t_we) check("issue_wdata", c_wdata, t_wdata);
                if (stalled < stall_n) begin
                    fetch_stall = 1'b1;
                    stalled++;
                end else begin
                    fetch_stall = 1'b0;
                end
            end
            if (ack) begin
                lat = cyc; rd = rdata; er = err;
                break;
            end
        end
        if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
        fetch_stall = 1'b0;
        copro_gnt = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er, sr;
    logic        seen;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; crn = 4'd0; wdata = 32'd0;
        copro_gnt = 1'b0; fetch_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_copro_req", {31'd0, copro_req}, 32'd0);
        check("rst_num", {28'd0, c_num}, 32'hf);
        check("rst_rdata", rdata, 32'd0);
        check("rst_misc", {c_op, c_crn, c_crm, op1, op2}, 32'd0);
        rst = 1'b0;

        // Write crn 3, then read it back.
        run_op(1'b1, 4'd3, 32'hdead_beef, 0, 0, lat, rd, er, sr);
        check("wr3_lat", lat, 32'd3);
        check("wr3_err", {31'd0, er}, 32'd0);
        check("wr3_rdata", rd, 32'd0);
        run_op(1'b0, 4'd3, 32'd0, 0, 0, lat, rd, er, sr);
        check("rd3_lat", lat, 32'd4);
        check("rd3_data", rd, 32'hdead_beef);
        @(negedge clk);
        check("idle_after", {31'd0, busy}, 32'd0);
        check("rdata_held", rdata, 32'hdead_beef);

        // Read crn 0.
        run_op(1'b0, 4'd0, 32'd0, 0, 0, lat, rd, er, sr);
        check("rd0_lat", lat, 32'd4);
        check("rd0_data", rd, 32'h1337_4141);
        check("rd0_err", {31'd0, er}, 32'd0);

        // Read crn 2 with five stalled ISSUE cycles.
        run_op(1'b0, 4'd2, 32'd0, 0, 5, lat, rd, er, sr);
        check("stall_lat", lat, 32'd9);
        check("stall_data", rd, 32'h0000_2222);

        // Out-of-range register.
        run_op(1'b1, 4'd9, 32'h1234_5678, 0, 0, lat, rd, er, sr);
        check("crn9_lat", lat, 32'd1);
        check("crn9_err", {31'd0, er}, 32'd1);
        check("crn9_rdata", rd, 32'd0);
        check("crn9_no_req", {31'd0, sr}, 32'd0);

        // Unfiltered write to crn 7.
        run_op(1'b1, 4'd7, 32'h0000_0077, 0, 0, lat, rd, er, sr);
        check("wr7_lat", lat, 32'd3);
        check("wr7_err", {31'd0, er}, 32'd0);

`ifdef A23_COPRO_GNT_TIMEOUT_EN
        run_op(1'b0, 4'd0, 32'd0, 1000, 0, lat, rd, er, sr);
        check("tmo_lat", lat, 32'd5);
        check("tmo_err", {31'd0, er}, 32'd1);
        check("tmo_rdata", rd, 32'd0);
`else
        // Grant withheld for 10 REQ cycles, then given.
        run_op(1'b0, 4'd0, 32'd0, 10, 0, lat, rd, er, sr);
        check("gntw_lat", lat, 32'd13);
        check("gntw_data", rd, 32'h1337_4141);
        check("gntw_err", {31'd0, er}, 32'd0);
`endif

        // Reset while in ISSUE.
        @(negedge clk);
        req = 1'b1; we = 1'b0; crn = 4'd2; copro_gnt = 1'b1; fetch_stall = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (c_op != 2'd0) seen = 1'b1;
        end
        check("rst_reached_issue", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_op", {30'd0, c_op}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; fetch_stall = 1'b0; copro_gnt = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        check("rst_no_ack", {31'd0, seen}, 32'd0);
        run_op(1'b0, 4'd3, 32'd0, 0, 0, lat, rd, er, sr);
        check("post_rst_lat", lat, 32'd4);
        check("post_rst_data", rd, 32'hdead_beef);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
